btn_shift_165_reader: RTL and testbench

BTN_SHIFT_165_READER -- requirements
Module: btn_shift_165_reader

---
 rtl/btn_shift_165_reader_pkg.sv | 16 +
 rtl/btn_shift_165_reader_debounce_bit.sv | 51 +++++
 rtl/btn_shift_165_reader.sv | 114 +++++++++++
 tb/tb_btn_shift_165_reader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_shift_165_reader_pkg.sv
// Shared constants for the 74HC165 button reader: scan FSM encodings and chain size.
package btn_shift_165_reader_pkg;

    localparam int N_BUTTONS = 16;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t ST_LOAD   = 3'd0;
    localparam scan_state_t ST_LATCH  = 3'd1;
    localparam scan_state_t ST_SAMPLE = 3'd2;
    localparam scan_state_t ST_SHIFT  = 3'd3;
    localparam scan_state_t ST_DONE   = 3'd4;

    localparam logic [3:0] BITCNT_LAST = 4'd15;

endpackage

// File: rtl/btn_shift_165_reader_debounce_bit.sv
// One button: frame-rate debounce counter, debounced level and registered edge pulses.
module debounce_bit #(
    parameter int DEB_WIDTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_raw,
    input  logic i_update,
    output logic o_btn,
    output logic o_pressed,
    output logic o_released
);

    localparam logic [DEB_WIDTH-1:0] CNT_ONE = 1;

    logic [DEB_WIDTH-1:0] r_cnt;
    logic                 r_btn;
    logic                 r_btn_d;
    logic                 r_pressed;
    logic                 r_released;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_btn      <= 1'b0;
            r_btn_d    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            // Edge pulses follow the btn change by one clk; btn_d also resets low so reset never pulses.
            r_btn_d    <= r_btn;
            r_pressed  <= r_btn & ~r_btn_d;
            r_released <= ~r_btn & r_btn_d;
            if (i_update) begin
                if (i_raw == r_btn) begin
                    r_cnt <= '0;
                end else if (&r_cnt) begin
                    r_btn <= ~r_btn;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

    assign o_btn      = r_btn;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/btn_shift_165_reader.sv
// Scans a chain of two 74HC165s at a divided tick rate and debounces the 16 active-low buttons.
module btn_shift_165_reader
    import btn_shift_165_reader_pkg::*;
#(
    parameter int SHIFT_DELAY_WIDTH = 8,
    parameter int DEB_WIDTH         = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ser,
    output logic                 sck,
    output logic                 pl_n,
    output logic [N_BUTTONS-1:0] btn,
    output logic [N_BUTTONS-1:0] pressed,
    output logic [N_BUTTONS-1:0] released,
    output logic                 frame_valid,
    output logic [2:0]           dbg_state
);

    localparam logic [SHIFT_DELAY_WIDTH:0] TICK_ONE = 1;

    logic [SHIFT_DELAY_WIDTH:0] r_tick_cnt;
    logic                       w_tick;
    scan_state_t                r_state;
    logic                       r_sck;
    logic                       r_pl_n;
    logic [3:0]                 r_bitcnt;
    logic [N_BUTTONS-1:0]       r_shreg;
    logic [N_BUTTONS-1:0]       r_raw;
    logic                       r_frame_valid;

    // Tick is the counter MSB; clearing on that cycle gives a 2^W+1 clk period.
    assign w_tick = r_tick_cnt[SHIFT_DELAY_WIDTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_LOAD;
            r_sck         <= 1'b0;
            r_pl_n        <= 1'b1;
            r_bitcnt      <= BITCNT_LAST;
            r_shreg       <= '0;
            r_raw         <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_LOAD: begin
                        r_pl_n   <= 1'b0;
                        r_sck    <= 1'b0;
                        r_bitcnt <= BITCNT_LAST;
                        r_state  <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        r_pl_n  <= 1'b1;
                        r_state <= ST_SAMPLE;
                    end
                    ST_SAMPLE: begin
                        r_sck   <= 1'b0;
                        r_shreg <= {r_shreg[N_BUTTONS-2:0], ser};
                        r_state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        r_sck <= 1'b1;
                        if (r_bitcnt == 4'd0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bitcnt <= r_bitcnt - 4'd1;
                            r_state  <= ST_SAMPLE;
                        end
                    end
                    ST_DONE: begin
                        // Buttons pull the 165 inputs low, so invert to get 1 = pressed.
                        r_sck         <= 1'b0;
                        r_raw         <= ~r_shreg;
                        r_frame_valid <= 1'b1;
                        r_state       <= ST_LOAD;
                    end
                    default: begin
                        r_state <= ST_LOAD;
                    end
                endcase
            end
        end
    end

    debounce_bit #(
        .DEB_WIDTH(DEB_WIDTH)
    ) u_deb [N_BUTTONS-1:0] (
        .clk       (clk),
        .resetn    (resetn),
        .i_raw     (r_raw),
        .i_update  (r_frame_valid),
        .o_btn     (btn),
        .o_pressed (pressed),
        .o_released(released)
    );

    assign sck         = r_sck;
    assign pl_n        = r_pl_n;
    assign frame_valid = r_frame_valid;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_btn_shift_165_reader.sv
// Bench for btn_shift_165_reader: 74HC165 chain model, frame-level reference model, per-cycle compare.
module tb_btn_shift_165_reader;

  localparam int SDW         = 2;
  localparam int DW          = 1;
  localparam int TICK_PERIOD = (1 << SDW) + 1;
  localparam int FRAME_CLKS  = 35 * TICK_PERIOD;
  localparam int DEB_FRAMES  = 1 << DW;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser;
  logic        sck;
  logic        pl_n;
  logic [15:0] btn;
  logic [15:0] pressed;
  logic [15:0] released;
  logic        frame_valid;
  logic [2:0]  dbg_state;

  logic [15:0] pins = 16'hFFFF;
  logic [15:0] chain = 16'hFFFF;
  logic        sck_q = 1'b0;
  bit          sb_on = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  btn_shift_165_reader #(
    .SHIFT_DELAY_WIDTH(SDW),
    .DEB_WIDTH(DW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ser(ser),
    .sck(sck),
    .pl_n(pl_n),
    .btn(btn),
    .pressed(pressed),
    .released(released),
    .frame_valid(frame_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // two cascaded 74HC165s: parallel load while pl_n low, shift on sck rising, serial-in tied high
  assign ser = chain[15];
  always @(posedge clk) begin
    if (!pl_n) chain <= pins;
    else if (sck && !sck_q) chain <= {chain[14:0], 1'b1};
    sck_q <= sck;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // reference model: frame timing from clk arithmetic, debounce as consecutive-disagreement streaks
  int unsigned m_n;
  int          m_q;
  int          m_t;
  int          m_streak[16];
  logic [15:0] m_btn, m_btn_old, m_pressed, m_released, m_frame_pins, m_raw;
  logic        m_fv, m_sck, m_pl_n;

  always @(posedge clk) begin
    if (!resetn) begin
      m_n = 0; m_btn = '0; m_btn_old = '0; m_pressed = '0; m_released = '0;
      m_fv = 1'b0; m_sck = 1'b0; m_pl_n = 1'b1;
      for (int i = 0; i < 16; i++) m_streak[i] = 0;
    end else begin
      m_pressed  = m_btn & ~m_btn_old;
      m_released = ~m_btn & m_btn_old;
      m_btn_old  = m_btn;
      if (m_fv) begin
        m_raw = ~m_frame_pins;
        for (int i = 0; i < 16; i++) begin
          if (m_raw[i] != m_btn[i]) begin
            m_streak[i]++;
            if (m_streak[i] == DEB_FRAMES) begin
              m_btn[i] = ~m_btn[i];
              m_streak[i] = 0;
            end
          end else begin
            m_streak[i] = 0;
          end
        end
      end
      m_n++;
      m_q = int'(m_n % FRAME_CLKS);
      m_t = m_q / TICK_PERIOD;
      m_fv   = (m_q == 0);
      m_pl_n = !(m_q >= TICK_PERIOD && m_q < 2 * TICK_PERIOD);
      m_sck  = (m_t >= 4 && m_t <= 34 && (m_t % 2) == 0);
      if (m_q == 2 * TICK_PERIOD) m_frame_pins = pins;
    end
  end

  // scoreboard: every cycle, all outputs against the model
  always @(negedge clk) begin
    if (sb_on)
      check("cycle_outputs",
            {13'd0, btn, pressed, released, frame_valid, sck, pl_n},
            {13'd0, m_btn, m_pressed, m_released, m_fv, m_sck, m_pl_n});
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output int clks, output int sck_rises, output int pl_lows,
                            output logic [15:0] press_seen);
    bit   found = 1'b0;
    logic prev = sck;
    clks = 0; sck_rises = 0; pl_lows = 0; press_seen = '0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clk);
      #1;
      clks++;
      if (sck && !prev) sck_rises++;
      prev = sck;
      if (!pl_n) pl_lows++;
      press_seen |= pressed;
      if (frame_valid) found = 1'b1;
    end
    if (!found) check("frame_timeout", 64'd0, 64'd1);
  endtask

  int          clks, rises, lows, pcnt;
  logic [15:0] pseen, pval;

  initial begin
    // reset state, button 0 pressed on the pins
    pins = 16'hFFFE;
    resetn = 1'b0;
    cycles(3);
    sb_on = 1'b1;
    check("reset_sck_pl_n", {62'd0, sck, pl_n}, 64'b01);
    check("reset_btn_pulses", {16'd0, btn, pressed, released}, 64'd0);
    check("reset_fv_state", {60'd0, frame_valid, dbg_state}, 64'd0);
    resetn = 1'b1;

    // frame timing and bit order
    wait_frame(clks, rises, lows, pseen);
    check("first_frame_clks", clks, FRAME_CLKS);
    check("sck_rises_per_frame", rises, 16);
    check("pl_n_low_clks", lows, 5);
    wait_frame(clks, rises, lows, pseen);
    check("second_frame_clks", clks, FRAME_CLKS);
    check("frame2_sck_rises", rises, 16);
    check("btn_before_update", btn, 16'h0000);
    cycles(1);
    check("btn_after_frame2", btn, 16'h0001);
    check("pressed_not_yet", pressed, 16'h0000);
    cycles(1);
    check("pressed_pulse", pressed, 16'h0001);
    cycles(1);
    check("pressed_cleared", pressed, 16'h0000);

    // bounce rejection
    resetn = 1'b0;
    cycles(2);
    check("btn_cleared_by_reset", btn, 16'h0000);
    resetn = 1'b1;
    pval = '0;
    for (int f = 0; f < 6; f++) begin
      pins = (f % 2 == 0) ? 16'hFFFE : 16'hFFFF;
      wait_frame(clks, rises, lows, pseen);
      pval |= pseen;
    end
    check("bounce_no_press", pval, 16'h0000);
    check("bounce_btn", btn, 16'h0000);

    // multi-bit press then release
    pins = 16'h7FFE;
    wait_frame(clks, rises, lows, pseen);
    wait_frame(clks, rises, lows, pseen);
    pins = 16'hFFFF;
    pcnt = 0; pval = '0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (pressed != 16'h0000) pcnt++;
      pval |= pressed;
    end
    check("multi_press_width", pcnt, 1);
    check("multi_press_value", pval, 16'h8001);
    check("multi_btn", btn, 16'h8001);
    wait_frame(clks, rises, lows, pseen);
    wait_frame(clks, rises, lows, pseen);
    pcnt = 0; pval = '0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (released != 16'h0000) pcnt++;
      pval |= released;
    end
    check("multi_release_width", pcnt, 1);
    check("multi_release_value", pval, 16'h8001);
    check("multi_btn_released", btn, 16'h0000);

    // random pin patterns, held for random frame counts
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) pins = 16'($urandom());
        else pins = ~(16'h0001 << $urandom_range(0, 15));
      end
      wait_frame(clks, rises, lows, pseen);
    end

    // reset in the middle of a frame
    pins = 16'hFFFE;
    for (int f = 0; f < 4; f++) wait_frame(clks, rises, lows, pseen);
    check("pre_reset_btn", btn, 16'h0001);
    cycles(20 * TICK_PERIOD - 1);
    resetn = 1'b0;
    cycles(1);
    check("midreset_sck_pl_n", {62'd0, sck, pl_n}, 64'b01);
    check("midreset_btn_fv", {47'd0, btn, frame_valid}, 64'd0);
    resetn = 1'b1;
    wait_frame(clks, rises, lows, pseen);
    check("post_reset_frame_clks", clks, FRAME_CLKS);
    check("post_reset_sck_rises", rises, 16);
    wait_frame(clks, rises, lows, pseen);
    cycles(3);

    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
